// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  // RV32I func3 width/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_ILLEGAL  = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_t;

  // Stores only know B/H/W; loads additionally accept the unsigned B/H forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/replication, load
// extraction with sign/zero extension, and func3/alignment fault detection.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_out,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] load_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Fault detection: illegal encoding, and halfword/word alignment by size code
  always_comb begin
    illegal = ~f3_legal(is_store, func3);
    case (func3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Store path: lane strobes and replicated write data (zero for loads)
  always_comb begin
    wstrb     = 4'b0000;
    wdata_out = 32'h0000_0000;
    if (is_store) begin
      case (func3)
        F3_B: begin
          wstrb     = 4'b0001 << lane;
          wdata_out = {4{wdata_in[7:0]}};
        end
        F3_H: begin
          wstrb     = 4'b0011 << lane;
          wdata_out = {2{wdata_in[15:0]}};
        end
        F3_W: begin
          wstrb     = 4'b1111;
          wdata_out = wdata_in;
        end
        default: begin
          wstrb     = 4'b0000;
          wdata_out = 32'h0000_0000;
        end
      endcase
    end else begin
      wstrb     = 4'b0000;
      wdata_out = 32'h0000_0000;
    end
  end

  // Load path: pick the addressed byte/half and extend to 32 bits
  always_comb begin
    case (lane)
      2'd0:    sel_byte = rdata[7:0];
      2'd1:    sel_byte = rdata[15:8];
      2'd2:    sel_byte = rdata[23:16];
      2'd3:    sel_byte = rdata[31:24];
      default: sel_byte = 8'h00;
    endcase
    if (lane[1]) begin
      sel_half = rdata[31:16];
    end else begin
      sel_half = rdata[15:0];
    end
    case (func3)
      F3_B:    load_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    load_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h00_0000, sel_byte};
      F3_HU:   load_data = {16'h0000, sel_half};
      default: load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per request, alignment/encoding
// traps, req/ready handshake with timeout, and load result formatting.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_is_store,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] op_addr,
  input  logic [31:0]       op_wdata,
  output logic              stall,
  output logic              op_done,
  output logic [31:0]       load_data,
  output logic              trap,
  output logic [1:0]        trap_cause,
  output logic [ADDR_W-1:0] trap_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              op_store;
  logic [2:0]        op_f3;
  logic [1:0]        op_lane;
  logic [ADDR_W-1:0] op_addr_q;

  logic              al_store;
  logic [2:0]        al_f3;
  logic [1:0]        al_lane;
  logic [3:0]        al_wstrb;
  logic [31:0]       al_wdata;
  logic              al_misaligned;
  logic              al_illegal;
  logic [31:0]       al_load;

  // Pipeline hold until the completion pulse
  assign stall = op_valid & ~op_done;

  // Lane aligner sees the live op in IDLE and the captured op afterwards
  always_comb begin
    if (state == IDLE) begin
      al_store = op_is_store;
      al_f3    = func3;
      al_lane  = op_addr[1:0];
    end else begin
      al_store = op_store;
      al_f3    = op_f3;
      al_lane  = op_lane;
    end
  end

  lsu_lane_align u_align (
    .is_store   (al_store),
    .func3      (al_f3),
    .lane       (al_lane),
    .wdata_in   (op_wdata),
    .rdata      (mem_rdata),
    .wstrb      (al_wstrb),
    .wdata_out  (al_wdata),
    .misaligned (al_misaligned),
    .illegal    (al_illegal),
    .load_data  (al_load)
  );

  // Control FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tmo_cnt    <= '0;
      op_store   <= 1'b0;
      op_f3      <= 3'b000;
      op_lane    <= 2'b00;
      op_addr_q  <= '0;
      op_done    <= 1'b0;
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
      trap_addr  <= '0;
      load_data  <= 32'h0000_0000;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wstrb  <= 4'b0000;
      mem_wdata  <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          op_done    <= 1'b0;
          trap       <= 1'b0;
          trap_cause <= CAUSE_NONE;
          if (op_valid) begin
            op_store  <= op_is_store;
            op_f3     <= func3;
            op_lane   <= op_addr[1:0];
            op_addr_q <= op_addr;
            if (al_illegal || al_misaligned) begin
              // Faulting op never reaches the bus; illegal outranks misaligned
              state      <= DONE;
              op_done    <= 1'b1;
              trap       <= 1'b1;
              trap_cause <= al_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
              trap_addr  <= op_addr;
              load_data  <= 32'h0000_0000;
            end else begin
              state     <= REQ;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= op_is_store;
              mem_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
              mem_wstrb <= al_wstrb;
              mem_wdata <= al_wdata;
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          if (mem_ready) begin
            state     <= DONE;
            op_done   <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
            load_data <= op_store ? 32'h0000_0000 : al_load;
          end else if (tmo_cnt == CNT_LAST) begin
            state      <= DONE;
            op_done    <= 1'b1;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
            trap_addr  <= op_addr_q;
            load_data  <= 32'h0000_0000;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_wstrb  <= 4'b0000;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          // Retiring op is still on op_valid here, so it is not resampled
          state      <= IDLE;
          op_done    <= 1'b0;
          trap       <= 1'b0;
          trap_cause <= CAUSE_NONE;
        end
        default: begin
          state     <= IDLE;
          op_done   <= 1'b0;
          trap      <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_wstrb <= 4'b0000;
        end
      endcase
    end
  end

endmodule
